// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//   Upstream control stage for a dsp48a1 slice. It accepts signed (A,B)
//   operand beats over valid/ready and drives slice A/B/OPMODE so that the
//   slice accumulates a dot product over each vector (terminated by S_LAST).
//   After the slice pipeline drains, P_IN is captured and presented as a
//   48-bit result over valid/ready. One vector is in flight at a time.
//
//   Optional feature macro: DSP_MAC_SEQUENCER_CNT_EN
//     adds M_COUNT, the saturating count of beats accepted in the vector.
//
// Ports
//   CLK, RST              clock (rising edge), synchronous active-high reset
//   S_A, S_B              signed 18-bit operands
//   S_VALID/S_READY/S_LAST operand beat handshake, end-of-vector marker
//   DSP_A, DSP_B          registered operands to the slice
//   DSP_OPMODE            slice OPMODE, delayed OP_DLY cycles behind DSP_A/B
//   DSP_RST               slice reset (follows RST)
//   P_IN                  slice P output
//   M_DATA/M_VALID/M_READY result handshake
//   M_COUNT               beats in the vector (DSP_MAC_SEQUENCER_CNT_EN only)

module dsp_mac_sequencer #(
   parameter int OP_DLY  = 2,
   parameter int RES_DLY = 3
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic signed [17:0] S_A,
   input  logic signed [17:0] S_B,
   input  logic               S_VALID,
   input  logic               S_LAST,
   output logic               S_READY,
   output logic signed [17:0] DSP_A,
   output logic signed [17:0] DSP_B,
   output logic [7:0]         DSP_OPMODE,
   output logic               DSP_RST,
   input  logic [47:0]        P_IN,
   output logic [47:0]        M_DATA,
   output logic               M_VALID,
   input  logic               M_READY
`ifdef DSP_MAC_SEQUENCER_CNT_EN
  ,output logic [15:0]        M_COUNT
`endif
);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

   // OPMODE encodings: X = OPMODE[1:0], Z = OPMODE[3:2]
   localparam logic [7:0] OP_NONE  = 8'h00;  // X=0, Z=0
   localparam logic [7:0] OP_FIRST = 8'h01;  // X=M, Z=0
   localparam logic [7:0] OP_ACC   = 8'h09;  // X=M, Z=P
   localparam logic [7:0] OP_HOLDP = 8'h08;  // X=0, Z=P

   localparam int CW = $clog2(RES_DLY + 2);

   state_t                state, state_nxt;
   logic                  fire;
   logic [7:0]            op_nxt;
   logic signed [17:0]    a_nxt, b_nxt;
   logic [CW-1:0]         drain_cnt;
   logic [7:0]            op_pipe [OP_DLY+1];
`ifdef DSP_MAC_SEQUENCER_CNT_EN
   logic [15:0]           beat_cnt;
`endif

   assign fire       = S_VALID & S_READY;
   assign DSP_RST    = RST;
   assign DSP_OPMODE = op_pipe[OP_DLY];

   always_comb begin
      state_nxt = state;
      op_nxt    = OP_NONE;
      a_nxt     = '0;
      b_nxt     = '0;
      case (state)
         IDLE: begin
            if (fire) begin
               op_nxt    = OP_FIRST;
               state_nxt = S_LAST ? DRAIN : ACCUM;
            end
         end
         ACCUM: begin
            if (fire) begin
               op_nxt = OP_ACC;
               if (S_LAST) state_nxt = DRAIN;
            end else begin
               op_nxt = OP_HOLDP;
            end
         end
         DRAIN: begin
            op_nxt = OP_HOLDP;
            if (drain_cnt == '0) state_nxt = HOLD;
         end
         HOLD: begin
            op_nxt = OP_HOLDP;
            if (M_READY) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (fire) begin
         a_nxt = S_A;
         b_nxt = S_B;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         S_READY   <= 1'b0;
         M_VALID   <= 1'b0;
         M_DATA    <= '0;
         DSP_A     <= '0;
         DSP_B     <= '0;
         drain_cnt <= '0;
         for (int unsigned i = 0; i <= OP_DLY; i++) op_pipe[i] <= '0;
`ifdef DSP_MAC_SEQUENCER_CNT_EN
         beat_cnt  <= '0;
         M_COUNT   <= '0;
`endif
      end else begin
         state   <= state_nxt;
         S_READY <= (state_nxt == IDLE) || (state_nxt == ACCUM);
         DSP_A   <= a_nxt;
         DSP_B   <= b_nxt;

         op_pipe[0] <= op_nxt;
         for (int unsigned i = 1; i <= OP_DLY; i++) op_pipe[i] <= op_pipe[i-1];

         // Loaded one above RES_DLY: the extra count covers the DSP_A/B
         // register stage, giving capture RES_DLY+2 edges after the last beat.
         if ((state != DRAIN) && (state_nxt == DRAIN))
            drain_cnt <= CW'(RES_DLY + 1);
         else if ((state == DRAIN) && (drain_cnt != '0))
            drain_cnt <= drain_cnt - CW'(1);

         if ((state == DRAIN) && (state_nxt == HOLD)) begin
            M_DATA  <= P_IN;
            M_VALID <= 1'b1;
`ifdef DSP_MAC_SEQUENCER_CNT_EN
            M_COUNT <= beat_cnt;
`endif
         end else if ((state == HOLD) && (state_nxt == IDLE)) begin
            M_VALID <= 1'b0;
         end

`ifdef DSP_MAC_SEQUENCER_CNT_EN
         if (fire) begin
            if (state == IDLE)
               beat_cnt <= 16'd1;
            else if (beat_cnt != 16'hFFFF)
               beat_cnt <= beat_cnt + 16'd1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer, driving a behavioural dsp48a1 slice
// (A1/B1, MREG, PREG registered; OPMODE unregistered).
module tb_dsp_mac_sequencer;

   localparam int OP_DLY  = 2;
   localparam int RES_DLY = 3;

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic signed [17:0] S_A = '0;
   logic signed [17:0] S_B = '0;
   logic               S_VALID = 1'b0;
   logic               S_LAST = 1'b0;
   logic               S_READY;
   logic signed [17:0] DSP_A, DSP_B;
   logic [7:0]         DSP_OPMODE;
   logic               DSP_RST;
   logic [47:0]        P_IN;
   logic [47:0]        M_DATA;
   logic               M_VALID;
   logic               M_READY = 1'b0;
`ifdef DSP_MAC_SEQUENCER_CNT_EN
   logic [15:0]        M_COUNT;
`endif

   dsp_mac_sequencer #(.OP_DLY(OP_DLY), .RES_DLY(RES_DLY)) dut (
      .CLK(CLK), .RST(RST), .S_A(S_A), .S_B(S_B), .S_VALID(S_VALID),
      .S_LAST(S_LAST), .S_READY(S_READY), .DSP_A(DSP_A), .DSP_B(DSP_B),
      .DSP_OPMODE(DSP_OPMODE), .DSP_RST(DSP_RST), .P_IN(P_IN),
      .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY)
`ifdef DSP_MAC_SEQUENCER_CNT_EN
     ,.M_COUNT(M_COUNT)
`endif
   );

   always #5 CLK = ~CLK;

   // Behavioural slice
   logic signed [17:0] a1 = '0, b1 = '0;
   logic signed [35:0] m = '0;
   logic [47:0]        p = '0;
   logic [47:0]        xs, zs;
   assign xs   = (DSP_OPMODE[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'd0;
   assign zs   = (DSP_OPMODE[3:2] == 2'b10) ? p : 48'd0;
   assign P_IN = p;
   always @(posedge CLK) begin
      if (DSP_RST) begin
         a1 <= '0; b1 <= '0; m <= '0; p <= '0;
      end else begin
         a1 <= DSP_A; b1 <= DSP_B; m <= a1 * b1; p <= zs + xs;
      end
   end

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct { logic [47:0] data; logic [15:0] cnt; } exp_t;
   exp_t   sb[$];
   longint acc = 0;
   int     beats = 0;
   int     last_acc_cyc = 0;
   int     n_checks = 0;
   int     n_fail = 0;

   task automatic send_beat(input logic signed [17:0] a, input logic signed [17:0] b,
                            input logic last);
      int    waited = 0;
      exp_t  e;
      logic [47:0] acc48;
      S_A = a; S_B = b; S_LAST = last; S_VALID = 1'b1;
      while (!S_READY && waited < 20) begin
         @(posedge CLK); #1; waited++;
      end
      if (!S_READY) begin
         n_checks++; n_fail++;
         $display("FAIL beat_accept: S_READY=%0b after %0d cycles, required 1", S_READY, waited);
      end else begin
         @(posedge CLK); #1;
         acc = acc + longint'(a) * longint'(b);
         beats++;
         if (last) begin
            acc48 = acc[47:0];
            e.data = acc48;
            e.cnt  = (beats > 65535) ? 16'hFFFF : 16'(beats);
            sb.push_back(e);
            acc = 0; beats = 0;
            last_acc_cyc = cyc;
         end
      end
      S_VALID = 1'b0; S_LAST = 1'b0; S_A = '0; S_B = '0;
   endtask

   task automatic bubble();
      @(posedge CLK); #1;
   endtask

   // Waits for M_VALID; returns observed data, count and latency from last beat.
   task automatic collect(output logic [47:0] d, output logic [15:0] c,
                          output int lat, output bit ok, output exp_t e);
      int waited = 0;
      ok = 1'b0; d = 'x; c = 'x; lat = -1;
      e.data = '1; e.cnt = '1;
      if (sb.size() != 0) e = sb.pop_front();
      while (waited < 40) begin
         @(posedge CLK); #1; waited++;
         if (M_VALID) begin
            ok = 1'b1; d = M_DATA; lat = cyc - last_acc_cyc;
`ifdef DSP_MAC_SEQUENCER_CNT_EN
            c = M_COUNT;
`else
            c = e.cnt;
`endif
            break;
         end
      end
   endtask

   task automatic ack();
      M_READY = 1'b1; @(posedge CLK); #1; M_READY = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      n_checks++;
      if ({S_READY, M_VALID} !== 2'b00) begin
         n_fail++; $display("FAIL reset_handshake: S_READY,M_VALID=%b required 00", {S_READY, M_VALID});
      end
      n_checks++;
      if (M_DATA !== 48'd0 || DSP_A !== 18'sd0 || DSP_B !== 18'sd0 || DSP_OPMODE !== 8'h00) begin
         n_fail++; $display("FAIL reset_data: M_DATA=%h A=%h B=%h OP=%h required zeros",
                            M_DATA, DSP_A, DSP_B, DSP_OPMODE);
      end
      RST = 1'b0;
      @(posedge CLK); #1;
      n_checks++;
      if (S_READY !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: S_READY=%b required 1", S_READY);
      end
   endtask

   task automatic test_basic_vector();
      logic [47:0] d; logic [15:0] c; int lat; bit ok; exp_t e;
      send_beat(18'sd3, 18'sd4, 1'b0);
      send_beat(18'sd5, 18'sd6, 1'b0);
      send_beat(-18'sd2, 18'sd7, 1'b1);
      collect(d, c, lat, ok, e);
      n_checks++;
      if (!ok || d !== e.data || d !== 48'd28) begin
         n_fail++; $display("FAIL basic_data: got %h required %h", d, e.data);
      end
      n_checks++;
      if (lat != RES_DLY + 2) begin
         n_fail++; $display("FAIL basic_latency: got %0d required %0d", lat, RES_DLY + 2);
      end
`ifdef DSP_MAC_SEQUENCER_CNT_EN
      n_checks++;
      if (c !== e.cnt) begin
         n_fail++; $display("FAIL basic_count: got %0d required %0d", c, e.cnt);
      end
`endif
      ack();
   endtask

   task automatic test_single_beat();
      logic [47:0] d; logic [15:0] c; int lat; bit ok; exp_t e;
      send_beat(-18'sd131072, -18'sd131072, 1'b1);
      collect(d, c, lat, ok, e);
      n_checks++;
      if (!ok || d !== e.data || d !== 48'h0004_0000_0000) begin
         n_fail++; $display("FAIL single_data: got %h required %h", d, e.data);
      end
      n_checks++;
      if (lat != RES_DLY + 2) begin
         n_fail++; $display("FAIL single_latency: got %0d required %0d", lat, RES_DLY + 2);
      end
`ifdef DSP_MAC_SEQUENCER_CNT_EN
      n_checks++;
      if (c !== 16'd1) begin
         n_fail++; $display("FAIL single_count: got %0d required 1", c);
      end
`endif
      ack();
   endtask

   // M_READY held high throughout: it must not disturb accumulation or drain.
   task automatic test_bubbles();
      logic [47:0] d; logic [15:0] c; int lat; bit ok; exp_t e;
      M_READY = 1'b1;
      send_beat(18'sd10, 18'sd10, 1'b0);
      bubble();
      bubble();
      send_beat(-18'sd1, 18'sd100, 1'b1);
      collect(d, c, lat, ok, e);
      n_checks++;
      if (!ok || d !== e.data || d !== 48'd0) begin
         n_fail++; $display("FAIL bubble_data: got %h required %h", d, e.data);
      end
      n_checks++;
      if (lat != RES_DLY + 2) begin
         n_fail++; $display("FAIL bubble_latency: got %0d required %0d", lat, RES_DLY + 2);
      end
`ifdef DSP_MAC_SEQUENCER_CNT_EN
      n_checks++;
      if (c !== 16'd2) begin
         n_fail++; $display("FAIL bubble_count: got %0d required 2", c);
      end
`endif
      @(posedge CLK); #1;
      M_READY = 1'b0;
      n_checks++;
      if (M_VALID !== 1'b0) begin
         n_fail++; $display("FAIL bubble_release: M_VALID=%b required 0", M_VALID);
      end
   endtask

   task automatic test_hold_backpressure();
      logic [47:0] d; logic [15:0] c; int lat; bit ok; exp_t e;
      int bad = 0;
      send_beat(18'sd9, -18'sd9, 1'b1);
      collect(d, c, lat, ok, e);
      n_checks++;
      if (!ok || d !== e.data) begin
         n_fail++; $display("FAIL hold_data: got %h required %h", d, e.data);
      end
      // Offer a junk beat during HOLD; it must not be taken.
      S_VALID = 1'b1; S_A = 18'sd99; S_B = 18'sd99; S_LAST = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1;
         n_checks++;
         if (M_VALID !== 1'b1 || M_DATA !== e.data || S_READY !== 1'b0) begin
            n_fail++; bad++;
            $display("FAIL hold_stable: cycle %0d M_VALID=%b M_DATA=%h S_READY=%b required 1 %h 0",
                     i, M_VALID, M_DATA, S_READY, e.data);
         end
      end
      S_VALID = 1'b0; S_LAST = 1'b0; S_A = '0; S_B = '0;
      ack();
      n_checks++;
      if (M_VALID !== 1'b0) begin
         n_fail++; $display("FAIL hold_ack: M_VALID=%b required 0", M_VALID);
      end
      send_beat(18'sd1, 18'sd1, 1'b0);
      send_beat(18'sd2, 18'sd2, 1'b1);
      collect(d, c, lat, ok, e);
      n_checks++;
      if (!ok || d !== e.data || d !== 48'd5) begin
         n_fail++; $display("FAIL after_hold_data: got %h required %h", d, e.data);
      end
      ack();
   endtask

   task automatic test_reset_mid_vector();
      logic [47:0] d; logic [15:0] c; int lat; bit ok; exp_t e;
      int seen = 0;
      send_beat(18'sd11, 18'sd12, 1'b0);
      send_beat(18'sd13, 18'sd14, 1'b0);
      RST = 1'b1;
      acc = 0; beats = 0;
      @(posedge CLK); #1;
      n_checks++;
      if ({S_READY, M_VALID} !== 2'b00 || M_DATA !== 48'd0 || DSP_A !== 18'sd0 ||
          DSP_B !== 18'sd0 || DSP_OPMODE !== 8'h00) begin
         n_fail++; $display("FAIL midreset_outputs: RDY=%b MV=%b MD=%h A=%h B=%h OP=%h required all 0",
                            S_READY, M_VALID, M_DATA, DSP_A, DSP_B, DSP_OPMODE);
      end
      RST = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1;
         if (M_VALID) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++; $display("FAIL midreset_no_result: M_VALID high %0d cycles, required 0", seen);
      end
      send_beat(18'sd7, -18'sd3, 1'b1);
      collect(d, c, lat, ok, e);
      n_checks++;
      if (!ok || d !== e.data || d !== 48'hFFFF_FFFF_FFEB) begin
         n_fail++; $display("FAIL midreset_fresh: got %h required %h", d, e.data);
      end
      ack();
   endtask

   task automatic test_back_to_back_long();
      logic [47:0] d; logic [15:0] c; int lat; bit ok; exp_t e;
      for (int i = 0; i < 300; i++) send_beat(18'sd1, 18'sd1, (i == 299));
      collect(d, c, lat, ok, e);
      n_checks++;
      if (!ok || d !== e.data || d !== 48'd300) begin
         n_fail++; $display("FAIL long_data: got %h required %h", d, e.data);
      end
      n_checks++;
      if (lat != RES_DLY + 2) begin
         n_fail++; $display("FAIL long_latency: got %0d required %0d", lat, RES_DLY + 2);
      end
`ifdef DSP_MAC_SEQUENCER_CNT_EN
      n_checks++;
      if (c !== 16'd300) begin
         n_fail++; $display("FAIL long_count: got %0d required 300", c);
      end
`endif
      ack();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_vector();
      test_single_beat();
      test_bubbles();
      test_hold_backpressure();
      test_reset_mid_vector();
      test_back_to_back_long();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
